// File: rtl/ft232r_reg_bridge.sv
// ----------------------------------------------------------------------------
// ft232r_reg_bridge
//
// Host-to-register packet decoder for the UART control link. Bytes arrive from
// the FT232R handshake adapter over a 4-phase req/ack handshake and are
// assembled into 16-bit register transactions:
//   Write : 'W' addr_h addr_l data_h data_l  -> response 'K'
//   Read  : 'R' addr_h addr_l                -> response data_h, data_l
//   Other :                                  -> response '?', err pulse
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   cmd_req/ack    4-phase byte handshake from the adapter, cmd_data[7:0]
//   rsp_req/ack    response handshake to the serializer, rsp_data[7:0]
//   reg_addr       16-bit register address (held until the next packet)
//   reg_wr_data    16-bit write data (held until the next packet)
//   reg_wr_en      1-cycle write strobe
//   reg_rd_en      1-cycle read strobe
//   reg_rd_data    read data, sampled P_RD_LATENCY cycles after reg_rd_en
//   busy           high whenever the packet FSM is not idle
//   err            1-cycle pulse on a bad opcode (or an inter-byte timeout)
//
// Optional feature: define FT232R_REG_BRIDGE_TIMEOUT_EN to abandon a partial
// packet after P_TIMEOUT_CYCLES of silence between bytes. Without it a partial
// packet waits indefinitely.
// ----------------------------------------------------------------------------
module ft232r_reg_bridge #(
    parameter int P_RD_LATENCY     = 2,
    parameter int P_TIMEOUT_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [7:0]  cmd_data,
    output logic        rsp_req,
    input  logic        rsp_ack,
    output logic [7:0]  rsp_data,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [3:0] RD_LAST  = 4'(P_RD_LATENCY);

    // Parameter sanity: the read wait counter is 4 bits and the timeout
    // comparison needs at least two cycles of headroom.
    if (P_RD_LATENCY < 1 || P_RD_LATENCY > 15 || P_TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ft232r_reg_bridge: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
        S_EXEC, S_RSP0, S_RSP1, S_ERR_RSP
    } state_e;

    typedef enum logic {
        RX_WAIT, RX_ACK
    } rx_state_e;

    state_e      state_q;
    rx_state_e   rx_state_q;
    logic        cmd_ack_q;
    logic        byte_valid_q;
    logic [7:0]  byte_q;
    logic        is_write_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        rsp_req_q;
    logic [7:0]  rsp_data_q;
    logic [7:0]  rd_lo_q;
    logic        wr_en_q;
    logic        rd_en_q;
    logic        err_q;
    logic [3:0]  cnt_q;
    logic        rx_open;

    // Bytes are only accepted while the packet FSM is collecting a packet;
    // during execution and responses cmd_req is simply left waiting.
    assign rx_open = (state_q == S_IDLE)   || (state_q == S_ADDR_H) ||
                     (state_q == S_ADDR_L) || (state_q == S_DATA_H) ||
                     (state_q == S_DATA_L);

    // Byte receive side of the 4-phase handshake: capture the byte and raise
    // ack when req is seen, then hold ack until req drops. byte_valid is a
    // single-cycle pulse telling the packet FSM a fresh byte is in byte_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_WAIT;
            cmd_ack_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            byte_valid_q <= 1'b0;
            case (rx_state_q)
                RX_WAIT: begin
                    if (cmd_req && rx_open) begin
                        byte_q       <= cmd_data;
                        cmd_ack_q    <= 1'b1;
                        byte_valid_q <= 1'b1;
                        rx_state_q   <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!cmd_req) begin
                        cmd_ack_q  <= 1'b0;
                        rx_state_q <= RX_WAIT;
                    end
                end
                default: rx_state_q <= RX_WAIT;
            endcase
        end
    end

`ifdef FT232R_REG_BRIDGE_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(P_TIMEOUT_CYCLES - 1);
    logic [23:0] tmo_q;
    logic        in_packet;
    assign in_packet = (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                       (state_q == S_DATA_H) || (state_q == S_DATA_L);
`endif

    // Packet FSM: walks the opcode/address/data bytes, fires the register
    // strobe, waits out the read latency and then plays out the response
    // bytes. cnt_q is shared between the read-latency wait in EXEC and the
    // forced low gap on rsp_req between the two read response bytes, so the
    // adapter's edge detector always sees a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rsp_req_q  <= 1'b0;
            rsp_data_q <= 8'h00;
            rd_lo_q    <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 4'd0;
`ifdef FT232R_REG_BRIDGE_TIMEOUT_EN
            tmo_q      <= 24'd0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (byte_valid_q) begin
                        if (byte_q == OP_WRITE) begin
                            is_write_q <= 1'b1;
                            state_q    <= S_ADDR_H;
                        end else if (byte_q == OP_READ) begin
                            is_write_q <= 1'b0;
                            state_q    <= S_ADDR_H;
                        end else begin
                            err_q      <= 1'b1;
                            rsp_data_q <= RSP_BAD;
                            rsp_req_q  <= 1'b1;
                            state_q    <= S_ERR_RSP;
                        end
                    end
                end
                S_ADDR_H: begin
                    if (byte_valid_q) begin
                        addr_q[15:8] <= byte_q;
                        state_q      <= S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (byte_valid_q) begin
                        addr_q[7:0] <= byte_q;
                        cnt_q       <= 4'd0;
                        if (is_write_q) begin
                            state_q <= S_DATA_H;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_DATA_H: begin
                    if (byte_valid_q) begin
                        wdata_q[15:8] <= byte_q;
                        state_q       <= S_DATA_L;
                    end
                end
                S_DATA_L: begin
                    if (byte_valid_q) begin
                        wdata_q[7:0] <= byte_q;
                        wr_en_q      <= 1'b1;
                        cnt_q        <= 4'd0;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_write_q) begin
                        rsp_data_q <= RSP_OK;
                        rsp_req_q  <= 1'b1;
                        state_q    <= S_RSP0;
                    end else if (cnt_q == RD_LAST) begin
                        rsp_data_q <= reg_rd_data[15:8];
                        rd_lo_q    <= reg_rd_data[7:0];
                        rsp_req_q  <= 1'b1;
                        state_q    <= S_RSP0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RSP0: begin
                    if (rsp_ack) begin
                        rsp_req_q <= 1'b0;
                        cnt_q     <= 4'd0;
                        state_q   <= is_write_q ? S_IDLE : S_RSP1;
                    end
                end
                S_RSP1: begin
                    if (rsp_req_q) begin
                        if (rsp_ack) begin
                            rsp_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else if (cnt_q == 4'd1) begin
                        rsp_data_q <= rd_lo_q;
                        rsp_req_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ERR_RSP: begin
                    if (rsp_ack) begin
                        rsp_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef FT232R_REG_BRIDGE_TIMEOUT_EN
            // A fresh byte always wins over an expiring count; the abandon
            // path overrides the case above only when no byte arrived.
            if (byte_valid_q || !in_packet) begin
                tmo_q <= 24'd0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_q   <= 24'd0;
                err_q   <= 1'b1;
                state_q <= S_IDLE;
            end else begin
                tmo_q <= tmo_q + 24'd1;
            end
`endif
        end
    end

    assign cmd_ack     = cmd_ack_q;
    assign rsp_req     = rsp_req_q;
    assign rsp_data    = rsp_data_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_ft232r_reg_bridge.sv
// ----------------------------------------------------------------------------
// tb_ft232r_reg_bridge
//
// Directed bench for ft232r_reg_bridge: plays the adapter side of the command
// handshake, the serializer side of the response handshake and a register
// file with a fixed read latency. Covers write, read, bad opcode,
// backpressure during a response, reset mid-packet and, when
// FT232R_REG_BRIDGE_TIMEOUT_EN is defined, the inter-byte timeout.
// ----------------------------------------------------------------------------
module tb_ft232r_reg_bridge;

    localparam int          RD_LAT   = 2;
    localparam int          TMO      = 100;
    localparam logic [15:0] RD_VALUE = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req;
    logic        cmd_ack;
    logic [7:0]  cmd_data;
    logic        rsp_req;
    logic        rsp_ack;
    logic [7:0]  rsp_data;
    logic [15:0] reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        busy;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    ft232r_reg_bridge #(
        .P_RD_LATENCY     (RD_LAT),
        .P_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_req     (cmd_req),
        .cmd_ack     (cmd_ack),
        .cmd_data    (cmd_data),
        .rsp_req     (rsp_req),
        .rsp_ack     (rsp_ack),
        .rsp_data    (rsp_data),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Register file model: read data is only valid exactly RD_LAT cycles
    // after the read strobe, so a DUT sampling at the wrong time sees 0xDEAD.
    logic [RD_LAT-1:0] rdDly = '0;
    always @(posedge clk) rdDly <= {rdDly[RD_LAT-2:0], reg_rd_en};
    assign reg_rd_data = rdDly[RD_LAT-1] ? RD_VALUE : 16'hDEAD;

    // Free-running cycle count plus a negedge monitor recording strobes,
    // error pulses and rsp_req edges for latency and gap checks.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wrCount = 0;
    int          rdCount = 0;
    int          errCount = 0;
    int          riseCount = 0;
    int          wrCyc = 0;
    int          rdCyc = 0;
    int          riseCyc = 0;
    int          fallCyc = 0;
    int          rspLowLen = 0;
    logic [15:0] wrAddr = '0;
    logic [15:0] wrData = '0;
    logic [15:0] rdAddr = '0;
    logic        rspPrev = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wrCount++;
            wrAddr = reg_addr;
            wrData = reg_wr_data;
            wrCyc  = cyc;
        end
        if (reg_rd_en) begin
            rdCount++;
            rdAddr = reg_addr;
            rdCyc  = cyc;
        end
        if (err) errCount++;
        if (rsp_req && !rspPrev) begin
            riseCount++;
            riseCyc   = cyc;
            rspLowLen = cyc - fallCyc;
        end
        if (!rsp_req && rspPrev) fallCyc = cyc;
        rspPrev = rsp_req;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Adapter side of one 4-phase byte transfer, called at a negedge.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        cmd_data = b;
        cmd_req  = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ack rise latency", cmd_ack, 1'b1);
        n = 0;
        while (!cmd_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmd_req = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ack fall latency", cmd_ack, 1'b0);
    endtask

    // Serializer side: wait for a response byte, then pulse rsp_ack once.
    task automatic getResponse(output logic [7:0] rspByte);
        int n;
        n = 0;
        while (!rsp_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_req rise", rsp_req, 1'b1);
        rspByte = rsp_data;
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        checkOutput("rsp_req fall after ack", rsp_req, 1'b0);
    endtask

    // Hard stop in case something escapes the bounded waits.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r0;
        logic [7:0] r1;
        int         firstRise;
        int         e0;
        int         w0;
        int         n;

        rst      = 1'b1;
        cmd_req  = 1'b0;
        cmd_data = 8'h00;
        rsp_ack  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset ctrl outputs",
                    {cmd_ack, rsp_req, reg_wr_en, reg_rd_en, busy, err}, 6'b0);
        checkOutput("reset rsp_data", rsp_data, 8'h00);
        checkOutput("reset reg_addr", reg_addr, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x1234 <= 0xABCD
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        getResponse(r0);
        @(negedge clk);
        checkOutput("write response", r0, 8'h4B);
        checkOutput("write strobe count", wrCount, 1);
        checkOutput("write addr", wrAddr, 16'h1234);
        checkOutput("write data", wrData, 16'hABCD);
        checkOutput("write rsp latency", riseCyc - wrCyc, 1);
        checkOutput("addr held after write", reg_addr, 16'h1234);
        checkOutput("busy after write", busy, 1'b0);

        // Read 0x00FF
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        getResponse(r0);
        firstRise = riseCyc;
        getResponse(r1);
        @(negedge clk);
        checkOutput("read rsp high byte", r0, 8'hBE);
        checkOutput("read rsp low byte", r1, 8'hEF);
        checkOutput("read strobe count", rdCount, 1);
        checkOutput("read addr", rdAddr, 16'h00FF);
        checkOutput("read rsp latency", firstRise - rdCyc, RD_LAT + 1);
        checkOutput("rsp_req low gap >= 2", rspLowLen >= 2, 1'b1);

        // Bad opcode, then a normal read
        e0 = errCount;
        applyStimulus(8'h41);
        getResponse(r0);
        @(negedge clk);
        checkOutput("bad opcode response", r0, 8'h3F);
        checkOutput("bad opcode err pulses", errCount - e0, 1);
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        getResponse(r0);
        getResponse(r1);
        @(negedge clk);
        checkOutput("read after error data", {r0, r1}, 16'hBEEF);
        checkOutput("read after error addr", rdAddr, 16'h0001);
        checkOutput("read after error strobes", rdCount, 2);

        // Backpressure: next opcode presented while the read response pends
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        cmd_data = 8'h57;
        cmd_req  = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("backpressure rsp pending", rsp_req, 1'b1);
        checkOutput("backpressure ack held low", cmd_ack, 1'b0);
        getResponse(r0);
        checkOutput("backpressure ack during gap", cmd_ack, 1'b0);
        getResponse(r1);
        checkOutput("backpressure read data", {r0, r1}, 16'hBEEF);
        n = 0;
        while (!cmd_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("backpressure ack after idle", cmd_ack, 1'b1);
        cmd_req = 1'b0;
        @(negedge clk);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        getResponse(r0);
        @(negedge clk);
        checkOutput("backpressure write response", r0, 8'h4B);
        checkOutput("backpressure write data", wrData, 16'h55AA);
        checkOutput("backpressure write count", wrCount, 2);

`ifdef FT232R_REG_BRIDGE_TIMEOUT_EN
        // Partial packet abandoned after the inter-byte timeout
        e0 = errCount;
        w0 = riseCount;
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("timeout busy cleared", busy, 1'b0);
        checkOutput("timeout delay window", (n >= 95 && n <= 105), 1'b1);
        checkOutput("timeout err pulse", errCount - e0, 1);
        checkOutput("timeout no response", riseCount - w0, 0);
        checkOutput("timeout no write", wrCount, 2);
`else
        // Partial packet simply waits without the timeout feature
        e0 = errCount;
        w0 = riseCount;
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        repeat (150) @(negedge clk);
        checkOutput("no timeout busy held", busy, 1'b1);
        checkOutput("no timeout err quiet", errCount - e0, 0);
        checkOutput("no timeout no response", riseCount - w0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        // Reset mid-packet
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        checkOutput("busy mid packet", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid-packet reset ctrl",
                    {cmd_ack, rsp_req, reg_wr_en, reg_rd_en, busy, err}, 6'b0);
        checkOutput("mid-packet reset rsp_data", rsp_data, 8'h00);
        checkOutput("mid-packet reset reg_addr", reg_addr, 16'h0000);
        checkOutput("mid-packet reset wr_data", reg_wr_data, 16'h0000);
        @(negedge clk);
        applyStimulus(8'h57);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        getResponse(r0);
        @(negedge clk);
        checkOutput("post-reset write response", r0, 8'h4B);
        checkOutput("post-reset write addr", wrAddr, 16'hABCD);
        checkOutput("post-reset write data", wrData, 16'h1234);
        checkOutput("post-reset write count", wrCount, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ft232r_reg_bridge.md
# ft232r_reg_bridge

Packet decoder sitting directly downstream of the FT232R handshake adapter. It consumes received bytes over the 4-phase `cmd_*` handshake and assembles them into 16-bit register read/write transactions. It drives a simple register bus and returns response bytes over the `rsp_*` handshake. This is the host-to-register path for the UART control link.

## Interface
- `P_RD_LATENCY`, 2: cycles from the `reg_rd_en` pulse to valid `reg_rd_data`; legal range 1–15.
- `P_TIMEOUT_CYCLES`, 12_500_000: inter-byte timeout in `clk` cycles (100 ms at 125 MHz); must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_req`  in  1  byte available from the adapter.
- `cmd_ack`  out  1  4-phase acknowledge to the adapter.
- `cmd_data`  in  8  received byte; stable while `cmd_req` is high.
- `rsp_req`  out  1  request to transmit `rsp_data`.
- `rsp_ack`  in  1  single-cycle done pulse from the serializer.
- `rsp_data`  out  8  byte to transmit; held stable while `rsp_req` is high.
- `reg_addr`  out  16  register address.
- `reg_wr_data`  out  16  write data.
- `reg_wr_en`  out  1  1-cycle write strobe.
- `reg_rd_en`  out  1  1-cycle read strobe.
- `reg_rd_data`  in  16  read data, sampled `P_RD_LATENCY` cycles after `reg_rd_en`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  1-cycle pulse on a bad opcode or a timeout.

## Operation
- Packet format:
  - Write: `0x57 ('W')`, addr[15:8], addr[7:0], data[15:8], data[7:0]. Response is `0x4B ('K')`.
  - Read: `0x52 ('R')`, addr[15:8], addr[7:0]. Response is data[15:8], then data[7:0].
  - Any other first byte: response `0x3F ('?')`, `err` pulses, return to IDLE.
- Byte receive sub-FSM (RX_WAIT, RX_ACK):
  - RX_WAIT: when `cmd_req`=1 and the main FSM is in a receive state, capture `cmd_data`, raise `cmd_ack`, emit an internal `byte_valid` pulse, and go to RX_ACK.
  - RX_ACK: hold `cmd_ack` high until `cmd_req`=0, then drop `cmd_ack` the next cycle and return to RX_WAIT.
- Main FSM: IDLE → ADDR_H → ADDR_L → (write: DATA_H → DATA_L →) EXEC → RSP0 → (read: RSP1 →) IDLE. ERR_RSP → IDLE.
  - IDLE uses the opcode byte to choose the path.
- EXEC behaviour:
  - Write: `reg_wr_en` high for 1 cycle.
  - Read: `reg_rd_en` high for 1 cycle, then wait `P_RD_LATENCY` cycles and latch `reg_rd_data`.
- `reg_addr` and `reg_wr_data` hold their last value until the next packet's bytes overwrite them.
- Backpressure: bytes are never acknowledged in EXEC, RSP0, RSP1 or ERR_RSP. `cmd_req` simply waits, and the adapter holds off the host.
- Reset mid-packet or mid-response:
  - All state returns to IDLE and the partial packet is discarded.
  - `rsp_req` and `cmd_ack` drop on the cycle after `rst` is sampled.

## Timing
- Every output resets to 0; `rsp_data`, `reg_addr` and `reg_wr_data` reset to 0x00 / 0x0000.
- `cmd_ack` rises 1 cycle after `cmd_req` is sampled high.
- `cmd_ack` falls 1 cycle after `cmd_req` is sampled low.
- Response handshake:
  - `rsp_data` is valid on the same cycle `rsp_req` rises.
  - `rsp_req` falls on the cycle after `rsp_ack` is sampled high.
  - `rsp_req` stays low for at least 2 cycles before the next rise, so the adapter's edge detector sees a fresh rising edge.
- Write latency: `reg_wr_en` pulses 1 cycle after the `byte_valid` of data[7:0]. `rsp_req` rises 1 cycle after the strobe.
- Read latency: `reg_rd_en` pulses 1 cycle after the `byte_valid` of addr[7:0]. `rsp_req` rises `P_RD_LATENCY`+1 cycles after the strobe.
- An `rsp_ack` arriving outside RSP0/RSP1 is ignored. A `cmd_req` arriving during a response waits and is not lost.

## Configuration
- Macro: `FT232R_REG_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A 24-bit counter clears on each `byte_valid` and counts while in ADDR_H, ADDR_L, DATA_H or DATA_L.
  - When the count reaches `P_TIMEOUT_CYCLES`−1: `err` pulses, the FSM returns to IDLE, and no response byte is sent.
- Undefined:
  - No counter is present.
  - A partial packet waits indefinitely.
  - `err` pulses only for a bad opcode.

## Test plan
- Write: send 57 12 34 AB CD → `reg_wr_en` pulses once with `reg_addr`=0x1234 and `reg_wr_data`=0xABCD; one response byte 0x4B.
- Read, `P_RD_LATENCY`=2, `reg_rd_data`=0xBEEF → `reg_rd_en` pulses with `reg_addr`=0x00FF; responses 0xBE then 0xEF, with `rsp_req` low ≥2 cycles between them.
- Bad opcode: send 0x41 → response 0x3F and one `err` pulse; a following 52 00 01 completes normally.
- Backpressure: present the next `cmd_req` while RSP0 is pending → `cmd_ack` stays 0 until the FSM reaches IDLE; the byte is then accepted intact.
- Timeout (macro defined, `P_TIMEOUT_CYCLES`=100): send 57 12, then idle for 100 cycles → `err` pulses, `busy`=0, and no `reg_wr_en`.
- Reset: assert `rst` for 1 cycle after 52 00 → all outputs are 0 next cycle; a following full write packet succeeds.
